// File: rtl/pipe_buffer.sv
// pipe_buffer: DEPTH-entry circular buffer stage with valid/ready handshakes and flush.
// Defining PIPE_BUFFER_BYPASS_EN adds a zero-latency path from input to output while empty.
module pipe_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [WIDTH-1:0]             data_in,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [WIDTH-1:0]             data_out,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             enq_s;
   logic             deq_s;
   logic             bypass_s;

   assign ready_in = (count_q < CW'(DEPTH)) && !flush;
   assign count    = count_q;

`ifdef PIPE_BUFFER_BYPASS_EN
   assign bypass_s = (count_q == CW'(0)) && !flush;

   // Output select: live input while empty, otherwise the head entry
   always_comb begin
      if (bypass_s) begin
         valid_out = valid_in;
         data_out  = data_in;
      end else begin
         valid_out = (count_q != CW'(0)) && !flush;
         data_out  = mem_q[rd_ptr_q];
      end
   end
`else
   assign bypass_s  = 1'b0;
   assign valid_out = (count_q != CW'(0)) && !flush;
   assign data_out  = mem_q[rd_ptr_q];
`endif

   // A beat taken straight through the bypass is never written into storage
   assign enq_s = valid_in && ready_in && !(bypass_s && ready_out);
   assign deq_s = valid_out && ready_out && (count_q != CW'(0));

   // Pointer and occupancy next-state
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (enq_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State update: reset beats flush, flush beats any handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (enq_s) begin
            mem_q[wr_ptr_q] <= data_in;
         end
      end
   end

endmodule

// File: tb/tb_pipe_buffer.sv
// Directed self-checking bench for pipe_buffer (WIDTH=8, DEPTH=4).
// Expectations for the same-cycle path follow PIPE_BUFFER_BYPASS_EN when it is defined.
module tb_pipe_buffer;
   logic       clk;
   logic       reset;
   logic       flush;
   logic       valid_in;
   logic       ready_in;
   logic [7:0] data_in;
   logic       valid_out;
   logic       ready_out;
   logic [7:0] data_out;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;
   int sent;
   int rcv;
   int cyc;
   logic en;
   logic de;

   pipe_buffer #(.WIDTH(8), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .data_in   (data_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .data_out  (data_out),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; valid_in = 1'b0; data_in = 8'h00; ready_out = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      chk("rst_rdy",  ready_in,  1);
      chk("rst_vld",  valid_out, 0);
      chk("rst_data", data_out,  0);
      chk("rst_cnt",  count,     0);

      // fill with downstream stalled
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1;
         data_in  = 8'(17 * (i + 1));
         #1;
         chk("fill_rdy", ready_in, 1);
         step();
      end
      data_in = 8'h55;
      #1;
      chk("fill_cnt",  count,     4);
      chk("fill_full", ready_in,  0);
      chk("fill_vld",  valid_out, 1);
      chk("fill_head", data_out,  8'h11);
      step();
      chk("fill_hold", count,    4);
      chk("fill_hd2",  data_out, 8'h11);

      // drain in arrival order
      valid_in  = 1'b0;
      ready_out = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_data", data_out,  8'(17 * (i + 1)));
         chk("drain_cnt",  count,     4 - i);
         chk("drain_vld",  valid_out, 1);
         step();
      end
      #1;
      chk("drain_cnt0", count,     0);
      chk("drain_vld0", valid_out, 0);
      ready_out = 1'b0;

      // full with simultaneous offer and accept: dequeue only
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1;
         data_in  = 8'(8'hB1 + i);
         step();
      end
      data_in   = 8'hC0;
      ready_out = 1'b1;
      #1;
      chk("fs_rdy0", ready_in, 0);
      step();
      chk("fs_cnt",  count,    3);
      chk("fs_rdy",  ready_in, 1);
      chk("fs_head", data_out, 8'hB2);
      valid_in  = 1'b0;
      ready_out = 1'b0;

      // flush with a same-cycle offer that must be dropped
      flush    = 1'b1;
      valid_in = 1'b1;
      data_in  = 8'h66;
      #1;
      chk("fl_vld", valid_out, 0);
      chk("fl_rdy", ready_in,  0);
      step();
      flush    = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("fl_cnt",  count,     0);
      chk("fl_vld2", valid_out, 0);
      step();
      chk("fl_cnt2", count,     0);
      chk("fl_vld3", valid_out, 0);

      // empty buffer, single beat with downstream ready
      valid_in  = 1'b1;
      data_in   = 8'hA5;
      ready_out = 1'b1;
      #1;
`ifdef PIPE_BUFFER_BYPASS_EN
      chk("bp_vld",  valid_out, 1);
      chk("bp_data", data_out,  8'hA5);
      chk("bp_cnt",  count,     0);
      step();
      valid_in = 1'b0;
      #1;
      chk("bp_cnt2", count,     0);
      chk("bp_vld2", valid_out, 0);
`else
      chk("bp_vld0", valid_out, 0);
      step();
      valid_in = 1'b0;
      #1;
      chk("bp_vld1", valid_out, 1);
      chk("bp_data", data_out,  8'hA5);
      chk("bp_cnt",  count,     1);
      step();
      chk("bp_cnt2", count,     0);
      chk("bp_vld2", valid_out, 0);
`endif
      ready_out = 1'b0;

      // stream 0x00..0x09 with random downstream stalls across pointer wrap
      sent = 0;
      rcv  = 0;
      cyc  = 0;
      while (rcv < 10 && cyc < 300) begin
         valid_in  = (sent < 10);
         data_in   = 8'(sent);
         ready_out = 1'($urandom_range(0, 1));
         #1;
         chk("wrap_cnt", count, sent - rcv);
         chk("wrap_max", count <= 3'd4, 1);
         chk("wrap_rdy", ready_in, (sent - rcv) < 4);
         en = valid_in && ready_in;
         de = valid_out && ready_out;
         if (de) begin
            chk("wrap_data", data_out, rcv);
            rcv++;
         end
         if (en) begin
            sent++;
         end
         step();
         cyc++;
      end
      chk("wrap_done", rcv, 10);
      valid_in  = 1'b0;
      ready_out = 1'b0;

      // reset while holding entries and offering another beat
      valid_in = 1'b1;
      data_in  = 8'h77;
      step();
      data_in = 8'h88;
      step();
      chk("mr_cnt",  count,    2);
      chk("mr_head", data_out, 8'h77);
      reset   = 1'b1;
      data_in = 8'h99;
      step();
      reset    = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("mr_cnt0", count,     0);
      chk("mr_vld",  valid_out, 0);
      chk("mr_data", data_out,  0);
      chk("mr_rdy",  ready_in,  1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_buffer.md
PIPE_BUFFER -- requirements
Module: pipe_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, entry count; legal values are powers of two >= 2.
REQ-003 The block SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all held entries (pipeline squash).
REQ-006 The block SHALL have port valid_in, input, 1, upstream offers data_in.
REQ-007 The block SHALL have port ready_in, output, 1, buffer can accept this cycle.
REQ-008 The block SHALL have port data_in, input, WIDTH, upstream payload.
REQ-009 The block SHALL have port valid_out, output, 1, data_out is valid.
REQ-010 The block SHALL have port ready_out, input, 1, downstream accepts this cycle.
REQ-011 The block SHALL have port data_out, output, WIDTH, payload to downstream.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1), current number of held entries.

Function
REQ-013 Storage SHALL be a DEPTH-entry circular buffer with read pointer, write pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-014 Enqueue SHALL occur when valid_in && ready_in; dequeue SHALL occur when valid_out && ready_out.
REQ-015 Entries SHALL leave in strict arrival order; no duplication, no loss except by flush or reset.
REQ-016 ready_in SHALL be (count < DEPTH) && !flush, with no combinational dependence on ready_out.
REQ-017 When full with ready_out=1, the dequeue SHALL happen, no enqueue SHALL happen, and ready_in SHALL be 1 on the next cycle.
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-019 count SHALL increment on enqueue-only, decrement on dequeue-only, and never exceed DEPTH or underflow below 0.
REQ-020 When count > 0, valid_out SHALL be 1 and data_out SHALL be the entry at the read pointer.
REQ-021 When flush=1, valid_out and ready_in SHALL be 0 that cycle; on the next edge pointers and count SHALL clear to 0 and data_in SHALL NOT be stored.
REQ-022 flush SHALL take priority over enqueue and dequeue; reset SHALL take priority over flush.
REQ-023 Without bypass, when count == 0, valid_out SHALL be 0, data_out SHALL be the entry at the read pointer, and minimum input-to-output latency SHALL be 1 cycle.

Reset
REQ-024 While reset=1, pointers, count and all storage entries SHALL clear to 0 at the clock edge.
REQ-025 After reset, outputs SHALL be ready_in=1, valid_out=0, data_out=0, count=0.
REQ-026 Reset asserted mid-transfer SHALL discard all held entries and any same-cycle enqueue.

Configuration
REQ-027 Macro PIPE_BUFFER_BYPASS_EN SHALL compile in a zero-latency bypass path.
REQ-028 With PIPE_BUFFER_BYPASS_EN defined, when count == 0 and flush=0, valid_out SHALL equal valid_in and data_out SHALL equal data_in combinationally.
REQ-029 With PIPE_BUFFER_BYPASS_EN defined, a beat consumed via the bypass (ready_out=1) SHALL NOT be stored, and count SHALL stay 0.
REQ-030 Without PIPE_BUFFER_BYPASS_EN, REQ-023 SHALL apply and no combinational path from data_in or valid_in to the outputs SHALL exist.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Fill test: after reset, push 0x11,0x22,0x33,0x44 with ready_out=0 -> count=4, ready_in=0; 0x55 is held upstream and not accepted.
REQ-032 Drain test: from the full state, set ready_out=1 -> data_out shows 0x11,0x22,0x33,0x44 on consecutive cycles, count steps 3,2,1,0, then valid_out=0.
REQ-033 Full plus simultaneous test: count=4, valid_in=1 and ready_out=1 -> dequeue only, count=3, ready_in=1 on the next cycle.
REQ-034 Flush test: count=3, assert flush with valid_in=1 and data_in=0x66 -> valid_out=0 and ready_in=0 that cycle; next cycle count=0 and 0x66 is never output.
REQ-035 Bypass test: empty buffer, valid_in=1, data_in=0xA5, ready_out=1 -> with the macro, valid_out=1 and data_out=0xA5 the same cycle, count=0; without the macro, valid_out=0 that cycle, then valid_out=1 with 0xA5 the next cycle.
REQ-036 Wrap test: stream 0x00..0x09 with random ready_out stalls -> output order is exactly 0x00..0x09 across pointer wrap, and count never exceeds 4.
